rst_seq_strobe_gen: RTL and testbench

- Parametrised reset-release sequencer for the clocking subsystem.
- Debounces the PLL lock indication and releases NUM_RST downstream reset domains one at a time, in order, with a programmable gap between releases.
- Once all domains are out of reset, generates a periodic one-cycle strobe for SERDES/gearbox alignment.
- Loss of lock or a soft reset request re-asserts all resets together and restarts the sequence.

---
 rtl/rst_seq_strobe_gen.sv | 169 ++++++++++++++++
 tb/tb_rst_seq_strobe_gen.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rst_seq_strobe_gen.sv
// rtl/rst_seq_strobe_gen.sv - PLL-lock debounced, ordered reset-release sequencer with RUN strobe
// Releases NUM_RST active-low resets one by one after a stable lock, then emits a periodic strobe.
module rst_seq_strobe_gen #(
   parameter int NUM_RST       = 4,
   parameter int SYNC_STAGES   = 2,
   parameter int LOCK_DEBOUNCE = 16,
   parameter int STEP_CYCLES   = 8,
   parameter int STB_DIV       = 4,
   parameter int CNT_W         = 8
) (
   input  logic               clk_sys,
   input  logic               rst_n,
   input  logic               pll_locked,
   input  logic               soft_rst,
   input  logic               lock_lost_clr,
   output logic [NUM_RST-1:0] rst_out_n,
   output logic               all_ready,
   output logic               strobe,
   output logic               lock_lost,
   output logic [1:0]         state
);

   typedef enum logic [1:0] {
      ST_HOLD     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_RELEASE  = 2'd2,
      ST_RUN      = 2'd3
   } state_t;

   // k runs one past the last channel so RUN is entered one edge after the final release
   localparam int KW = $clog2(NUM_RST + 1);
   localparam logic [KW-1:0]    K_DONE    = KW'(NUM_RST);
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(LOCK_DEBOUNCE - 1);
   localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
   localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(STB_DIV - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   lock_s;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [KW-1:0]          k_q, k_d;
   logic [NUM_RST-1:0]     rst_out_n_q, rst_out_n_d;
   logic                   all_ready_q, all_ready_d;
   logic                   strobe_q, strobe_d;
   logic                   lock_lost_q, lock_lost_d;
   logic                   abort;
   logic                   lock_drop;

   assign sync_d = {sync_q[SYNC_STAGES-2:0], pll_locked};
   assign lock_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      k_d         = k_q;
      rst_out_n_d = rst_out_n_q;
      strobe_d    = 1'b0;
      abort       = 1'b0;
      lock_drop   = 1'b0;

      case (state_q)
         ST_HOLD: begin
            rst_out_n_d = '0;
            cnt_d       = '0;
            k_d         = '0;
            if (lock_s) begin
               state_d = ST_DEBOUNCE;
            end
         end

         ST_DEBOUNCE: begin
            if (!lock_s) begin
               abort = 1'b1;
            end else if (cnt_q == DEB_LAST) begin
               state_d = ST_RELEASE;
               cnt_d   = '0;
               k_d     = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_RELEASE: begin
            if (!lock_s || soft_rst) begin
               abort     = 1'b1;
               lock_drop = !lock_s;
            end else if (k_q == K_DONE) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else if (cnt_q == STEP_LAST) begin
               cnt_d = '0;
               k_d   = k_q + KW'(1);
               for (int i = 0; i < NUM_RST; i++) begin
                  if (k_q == KW'(i)) begin
                     rst_out_n_d[i] = 1'b1;
                  end
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_RUN: begin
            if (!lock_s || soft_rst) begin
               abort     = 1'b1;
               lock_drop = !lock_s;
            end else if (cnt_q == STB_LAST) begin
               cnt_d    = '0;
               strobe_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: begin
            state_d = ST_HOLD;
         end
      endcase

      // Every channel drops on the same edge; resets are never de-sequenced
      if (abort) begin
         state_d     = ST_HOLD;
         cnt_d       = '0;
         k_d         = '0;
         rst_out_n_d = '0;
         strobe_d    = 1'b0;
      end

      all_ready_d = (state_d == ST_RUN);

      if (lock_drop) begin
         lock_lost_d = 1'b1;
      end else if (lock_lost_clr) begin
         lock_lost_d = 1'b0;
      end else begin
         lock_lost_d = lock_lost_q;
      end
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         sync_q      <= '0;
         state_q     <= ST_HOLD;
         cnt_q       <= '0;
         k_q         <= '0;
         rst_out_n_q <= '0;
         all_ready_q <= 1'b0;
         strobe_q    <= 1'b0;
         lock_lost_q <= 1'b0;
      end else begin
         sync_q      <= sync_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         k_q         <= k_d;
         rst_out_n_q <= rst_out_n_d;
         all_ready_q <= all_ready_d;
         strobe_q    <= strobe_d;
         lock_lost_q <= lock_lost_d;
      end
   end

   assign rst_out_n = rst_out_n_q;
   assign all_ready = all_ready_q;
   assign strobe    = strobe_q;
   assign lock_lost = lock_lost_q;
   assign state     = state_q;

endmodule

// File: tb/tb_rst_seq_strobe_gen.sv
// tb/tb_rst_seq_strobe_gen.sv - scoreboard bench for rst_seq_strobe_gen (default and minimal parameters)
module tb_rst_seq_strobe_gen;

   logic       clk = 1'b0;
   logic       rst_n, pll_locked, soft_rst, lock_lost_clr;
   logic [3:0] rst_out_n;
   logic       all_ready, strobe, lock_lost;
   logic [1:0] state;

   logic       sw_rst_n, sw_lock, sw_soft, sw_clr;
   logic [0:0] sw_rst_out_n;
   logic       sw_all_ready, sw_strobe, sw_lock_lost;
   logic [1:0] sw_state;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int t0       = 0;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } exp_t;
   exp_t sb_q[$];

   localparam int S_RST = 0, S_RDY = 1, S_STB = 2, S_ST = 3, S_LL = 4;
   localparam int W_RST = 5, W_RDY = 6, W_STB = 7, W_ST = 8, W_LL = 9;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rst_seq_strobe_gen u_dut (
      .clk_sys       (clk),
      .rst_n         (rst_n),
      .pll_locked    (pll_locked),
      .soft_rst      (soft_rst),
      .lock_lost_clr (lock_lost_clr),
      .rst_out_n     (rst_out_n),
      .all_ready     (all_ready),
      .strobe        (strobe),
      .lock_lost     (lock_lost),
      .state         (state)
   );

   rst_seq_strobe_gen #(
      .NUM_RST       (1),
      .SYNC_STAGES   (2),
      .LOCK_DEBOUNCE (1),
      .STEP_CYCLES   (1),
      .STB_DIV       (1),
      .CNT_W         (8)
   ) u_sweep (
      .clk_sys       (clk),
      .rst_n         (sw_rst_n),
      .pll_locked    (sw_lock),
      .soft_rst      (sw_soft),
      .lock_lost_clr (sw_clr),
      .rst_out_n     (sw_rst_out_n),
      .all_ready     (sw_all_ready),
      .strobe        (sw_strobe),
      .lock_lost     (sw_lock_lost),
      .state         (sw_state)
   );

   function automatic logic [31:0] get_sig(input int sel);
      case (sel)
         S_RST:   return 32'(rst_out_n);
         S_RDY:   return 32'(all_ready);
         S_STB:   return 32'(strobe);
         S_ST:    return 32'(state);
         S_LL:    return 32'(lock_lost);
         W_RST:   return 32'(sw_rst_out_n);
         W_RDY:   return 32'(sw_all_ready);
         W_STB:   return 32'(sw_strobe);
         W_ST:    return 32'(sw_state);
         W_LL:    return 32'(sw_lock_lost);
         default: return 32'hdead_beef;
      endcase
   endfunction

   task automatic push(input string tag, input int exp);
      exp_t e;
      e.tag = tag;
      e.exp = 32'(exp);
      sb_q.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic compare(input logic [31:0] obs);
      exp_t e;
      if (sb_q.size() == 0) begin
         failures++;
         $error("FAIL sb_underflow observed=%0d expected=<none>", obs);
      end else begin
         e = sb_q.pop_front();
         checks++;
         assert (obs === e.exp)
         else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
         end
      end
   endtask

   task automatic chk(input int sel);
      compare(get_sig(sel));
   endtask

   // Edge (relative to t0) at which sel first shows val; -1 if the budget expires
   task automatic chk_at(input int sel, input int val, input int budget);
      logic [31:0] when;
      bit          found;
      when  = 32'hffff_ffff;
      found = 1'b0;
      for (int i = 0; i < budget && !found; i++) begin
         @(negedge clk);
         if (get_sig(sel) === 32'(val)) begin
            when  = 32'(cyc - t0);
            found = 1'b1;
         end
      end
      compare(when);
   endtask

   initial begin
      rst_n = 1'b0; pll_locked = 1'b1; soft_rst = 1'b0; lock_lost_clr = 1'b0;
      sw_rst_n = 1'b0; sw_lock = 1'b1; sw_soft = 1'b0; sw_clr = 1'b0;
      step(10);

      push("reset_rst_out_n", 0); push("reset_all_ready", 0); push("reset_strobe", 0);
      push("reset_lock_lost", 0); push("reset_state", 0);
      chk(S_RST); chk(S_RDY); chk(S_STB); chk(S_LL); chk(S_ST);

      rst_n = 1'b1; t0 = cyc;
      push("pu_rel0", 27); push("pu_rel1", 35); push("pu_rel2", 43); push("pu_rel3", 51);
      push("pu_all_ready", 52); push("pu_strobe0", 56); push("pu_strobe_width", 0);
      push("pu_strobe1", 60); push("pu_strobe2", 64); push("pu_lock_lost", 0);
      chk_at(S_RST, 1, 40); chk_at(S_RST, 3, 20); chk_at(S_RST, 7, 20); chk_at(S_RST, 15, 20);
      chk_at(S_RDY, 1, 10); chk_at(S_STB, 1, 10);
      step(1); chk(S_STB);
      chk_at(S_STB, 1, 10); chk_at(S_STB, 1, 10);
      chk(S_LL);

      step(1);
      pll_locked = 1'b0; t0 = cyc;
      push("run_drop_edge", 3); push("run_drop_ready", 0); push("run_drop_strobe", 0);
      push("run_drop_lock_lost", 1); push("run_drop_state", 0);
      chk_at(S_RST, 0, 6); chk(S_RDY); chk(S_STB); chk(S_LL); chk(S_ST);

      lock_lost_clr = 1'b1; step(1); lock_lost_clr = 1'b0;
      push("lock_lost_clear", 0); chk(S_LL);

      pll_locked = 1'b1; t0 = cyc;
      push("relock_rel0", 27); push("relock_rel1", 35);
      chk_at(S_RST, 1, 40); chk_at(S_RST, 3, 20);

      pll_locked = 1'b0; t0 = cyc;
      step(2); push("mid_rel_still_0011", 3); chk(S_RST);
      step(1);
      push("mid_rel_drop_both", 0); push("mid_rel_lock_lost", 1); push("mid_rel_state", 0);
      chk(S_RST); chk(S_LL); chk(S_ST);
      lock_lost_clr = 1'b1; step(1); lock_lost_clr = 1'b0;

      pll_locked = 1'b1; t0 = cyc;
      push("relock_all_ready", 52); chk_at(S_RDY, 1, 70);
      step(3);
      soft_rst = 1'b1; t0 = cyc; step(1); soft_rst = 1'b0;
      push("soft_rst_out_n", 0); push("soft_state", 0); push("soft_lock_lost", 0);
      chk(S_RST); chk(S_ST); chk(S_LL);
      step(1); push("soft_debounce_entry", 1); chk(S_ST);
      step(1); soft_rst = 1'b1; step(1); soft_rst = 1'b0;
      push("soft_in_debounce_ignored", 1); chk(S_ST);
      push("soft_replay_rel0", 26); push("soft_replay_ready", 51); push("soft_replay_strobe", 55);
      push("soft_replay_lock_lost", 0);
      chk_at(S_RST, 1, 40); chk_at(S_RDY, 1, 40); chk_at(S_STB, 1, 10); chk(S_LL);

      rst_n = 1'b0; pll_locked = 1'b0; step(3); rst_n = 1'b1; step(2);
      pll_locked = 1'b1; t0 = cyc;
      step(10); pll_locked = 1'b0;
      step(2); push("glitch_still_debounce", 1); chk(S_ST);
      step(1); push("glitch_hold", 0); push("glitch_lock_lost", 0); chk(S_ST); chk(S_LL);
      pll_locked = 1'b1; t0 = cyc;
      push("glitch_restart_rel0", 27); chk_at(S_RST, 1, 40);

      sw_rst_n = 1'b1; t0 = cyc;
      push("sweep_rel", 5); push("sweep_ready", 6); push("sweep_strobe0", 7);
      push("sweep_strobe1", 1); push("sweep_strobe2", 1);
      chk_at(W_RST, 1, 10); chk_at(W_RDY, 1, 5); chk_at(W_STB, 1, 5);
      step(1); chk(W_STB);
      step(1); chk(W_STB);

      sw_lock = 1'b0; sw_clr = 1'b1; step(3);
      push("sweep_set_wins_clr", 1); push("sweep_drop_rst", 0); push("sweep_drop_state", 0);
      chk(W_LL); chk(W_RST); chk(W_ST);
      sw_clr = 1'b0; step(1);
      push("sweep_lock_lost_sticky", 1); chk(W_LL);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
